// File: rtl/ram_sp_be_init.sv
// Single-port RAM with per-column write enables and a post-reset clear to INIT_VAL.
// Read latency 1, or 2 with RAM_SP_BE_OUT_REG_EN; no backpressure, accesses ignored while init_busy_o.
// RAM_SP_BE_OUT_REG_EN adds a second output register stage.
module ram_sp_be_init #(
  parameter int                ADR_WD   = 6,
  parameter int                DAT_WD   = 23,
  parameter int                COL_WD   = 23,
  parameter logic [DAT_WD-1:0] INIT_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [ADR_WD-1:0]        adr_i,
  input  logic [DAT_WD/COL_WD-1:0] wr_ena_i,
  input  logic [DAT_WD-1:0]        wr_dat_i,
  input  logic                     rd_ena_i,
  output logic [DAT_WD-1:0]        rd_dat_o,
  output logic                     rd_vld_o,
  output logic                     init_busy_o
);

  localparam int COL_NUM = DAT_WD / COL_WD;
  localparam int DEP     = 1 << ADR_WD;

  typedef enum logic {INIT, READY} state_t;

  state_t              state, state_nxt;
  logic [ADR_WD-1:0]   cnt, cnt_nxt;
  logic                init_wr;
  logic                user_wr;
  logic                rd_acc;
  logic [DAT_WD-1:0]   mem [DEP];
  logic [DAT_WD-1:0]   rd_dat_q;
  logic                rd_vld_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    init_wr   = 1'b0;
    user_wr   = 1'b0;
    rd_acc    = 1'b0;
    case (state)
      INIT: begin
        init_wr = 1'b1;
        cnt_nxt = cnt + ADR_WD'(1);
        if (cnt == ADR_WD'(DEP - 1)) state_nxt = READY;
      end
      READY: begin
        user_wr = 1'b1;
        rd_acc  = rd_ena_i;
      end
      default: state_nxt = INIT;
    endcase
  end

  assign init_busy_o = (state == INIT);

  // Array has no reset; a reset cycle must not disturb its contents.
  always_ff @(posedge clk) begin
    if (rstn) begin
      if (init_wr) begin
        mem[cnt] <= INIT_VAL;
      end else if (user_wr) begin
        for (int k = 0; k < COL_NUM; k++) begin
          if (wr_ena_i[k]) mem[adr_i][k*COL_WD +: COL_WD] <= wr_dat_i[k*COL_WD +: COL_WD];
        end
      end
    end
  end

  // Read samples the array before this edge's write lands: read-first.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_dat_q <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_acc;
      if (rd_acc) rd_dat_q <= mem[adr_i];
    end
  end

`ifdef RAM_SP_BE_OUT_REG_EN
  logic [DAT_WD-1:0] rd_dat_q2;
  logic              rd_vld_q2;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_dat_q2 <= '0;
      rd_vld_q2 <= 1'b0;
    end else begin
      rd_vld_q2 <= rd_vld_q;
      if (rd_vld_q) rd_dat_q2 <= rd_dat_q;
    end
  end

  assign rd_dat_o = rd_dat_q2;
  assign rd_vld_o = rd_vld_q2;
`else
  assign rd_dat_o = rd_dat_q;
  assign rd_vld_o = rd_vld_q;
`endif

endmodule

// File: tb/tb_ram_sp_be_init.sv
// Bench for ram_sp_be_init: randomized traffic against a behavioural array model plus directed literal checks.
module tb_ram_sp_be_init;

`ifdef RAM_SP_BE_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rstn;

  logic [5:0]  a_adr;
  logic        a_wr;
  logic [22:0] a_wdat;
  logic        a_rd;
  logic [22:0] a_dat;
  logic        a_vld;
  logic        a_busy;

  logic [5:0]  b_adr;
  logic [3:0]  b_wr;
  logic [31:0] b_wdat;
  logic        b_rd;
  logic [31:0] b_dat;
  logic        b_vld;
  logic        b_busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ram_sp_be_init dut_a (
    .clk(clk), .rstn(rstn), .adr_i(a_adr), .wr_ena_i(a_wr), .wr_dat_i(a_wdat),
    .rd_ena_i(a_rd), .rd_dat_o(a_dat), .rd_vld_o(a_vld), .init_busy_o(a_busy)
  );

  ram_sp_be_init #(.ADR_WD(6), .DAT_WD(32), .COL_WD(8), .INIT_VAL(32'hDEADBEEF)) dut_b (
    .clk(clk), .rstn(rstn), .adr_i(b_adr), .wr_ena_i(b_wr), .wr_dat_i(b_wdat),
    .rd_ena_i(b_rd), .rd_dat_o(b_dat), .rd_vld_o(b_vld), .init_busy_o(b_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: busy for 64 enabled edges after reset, then the whole array equals 0.
  logic [22:0] m_mem [64];
  int          busy_left = 0;
  logic        q_vld [2];
  logic [22:0] q_dat [2];

  always @(posedge clk) begin
    if (!rstn) begin
      busy_left = 64;
      q_vld[0] = 1'b0; q_vld[1] = 1'b0;
      q_dat[0] = '0;   q_dat[1] = '0;
    end else begin
      if (q_vld[0]) q_dat[1] = q_dat[0];
      q_vld[1] = q_vld[0];
      if (busy_left > 0) begin
        busy_left--;
        q_vld[0] = 1'b0;
        if (busy_left == 0) foreach (m_mem[i]) m_mem[i] = '0;
      end else begin
        q_vld[0] = a_rd;
        if (a_rd) q_dat[0] = m_mem[a_adr];
        if (a_wr) m_mem[a_adr] = a_wdat;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(a_busy), 64'(busy_left > 0));
      chk("rd_vld", 64'(q_vld[LAT-1]), 64'(a_vld));
      chk("rd_dat", 64'(a_dat), 64'(q_dat[LAT-1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_rd = 1'b0; a_wr = 1'b0;
  endtask

  task automatic rand_a();
    logic [31:0] r;
    r = $urandom;
    a_wdat = r[22:0];
    a_adr  = 6'($urandom_range(0, 63));
    a_rd   = 1'($urandom_range(0, 1));
    a_wr   = 1'($urandom_range(0, 1));
  endtask

  // Counts busy cycles from reset release, stimulating with ignored random traffic.
  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (!a_busy) break;
      n++;
      chk({name, "_vld"}, 64'(a_vld), 64'd0);
      chk({name, "_dat"}, 64'(a_dat), 64'd0);
      tick();
      rand_a();
    end
    chk(name, 64'(n), 64'd64);
    idle();
  endtask

  initial begin
    rstn = 1'b0;
    a_adr = '0; a_wdat = '0; idle();
    b_adr = '0; b_wr = '0; b_wdat = '0; b_rd = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy", 64'(a_busy), 64'd1);
    chk("rst_vld", 64'(a_vld), 64'd0);
    chk("rst_dat", 64'(a_dat), 64'd0);
    chk_en = 1'b1;
    tick();
    rstn = 1'b1;
    wait_init("init_len");

    for (int a = 0; a < 64; a++) begin
      tick(); a_rd = 1'b1; a_adr = 6'(a);
    end
    tick(); idle();
    repeat (3) tick();

    // Column enables over a non-zero INIT_VAL
    b_adr = 6'd5; b_wr = 4'b0101; b_wdat = 32'h11223344;
    tick(); b_wr = '0; b_rd = 1'b1;
    tick(); b_rd = 1'b0;
    repeat (LAT - 1) tick();
    @(negedge clk);
    chk("b_col_vld", 64'(b_vld), 64'd1);
    chk("b_col_dat", 64'(b_dat), 64'h00000000DE22BE44);
    tick(); b_adr = 6'd6; b_rd = 1'b1;
    tick(); b_rd = 1'b0;
    repeat (LAT - 1) tick();
    @(negedge clk);
    chk("b_init_dat", 64'(b_dat), 64'h00000000DEADBEEF);

    // Read-first on a same-cycle write
    tick(); a_adr = 6'd10; a_wr = 1'b1; a_wdat = 23'h7FFFFF; a_rd = 1'b1;
    tick(); idle();
    repeat (LAT - 1) tick();
    @(negedge clk);
    chk("rf_vld", 64'(a_vld), 64'd1);
    chk("rf_old", 64'(a_dat), 64'd0);
    tick(); a_rd = 1'b1; a_adr = 6'd10;
    tick(); idle();
    repeat (LAT - 1) tick();
    @(negedge clk);
    chk("rf_new", 64'(a_dat), 64'h7FFFFF);

    for (int a = 0; a < 64; a++) begin
      tick(); a_wr = 1'b1; a_adr = 6'(a); a_wdat = 23'(a * 3);
    end
    tick(); idle();
    for (int i = 0; i < 64 + LAT; i++) begin
      tick();
      if (i < 64) begin a_rd = 1'b1; a_adr = 6'(63 - i); end
      else idle();
      @(negedge clk);
      if (i >= LAT) begin
        chk("b2b_vld", 64'(a_vld), 64'd1);
        chk("b2b_dat", 64'(a_dat), 64'((63 - (i - LAT)) * 3));
      end
    end

    repeat (400) begin
      tick(); rand_a();
    end
    tick(); idle();

    // Single read latency, then reset with a read in flight
    tick(); a_wr = 1'b1; a_adr = 6'd7; a_wdat = 23'h000123;
    tick(); idle();
    tick(); a_rd = 1'b1; a_adr = 6'd7;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("lat_vld", 64'(a_vld), 64'(c == LAT));
      if (c == LAT) chk("lat_dat", 64'(a_dat), 64'h000123);
      tick(); a_rd = 1'b0;
    end
    a_rd = 1'b1; a_adr = 6'd7;
    tick(); a_rd = 1'b0; rstn = 1'b0;
    tick(); rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("flush_vld", 64'(a_vld), 64'd0);
      tick();
    end

    // Reset mid-clear restarts the full sweep
    rstn = 1'b0;
    tick(); rstn = 1'b1;
    repeat (30) tick();
    rstn = 1'b0;
    tick(); rstn = 1'b1;
    wait_init("reinit_len");
    tick(); a_rd = 1'b1; a_adr = 6'd0;
    tick(); idle();
    repeat (LAT - 1) tick();
    @(negedge clk);
    chk("post_reinit", 64'(a_dat), 64'd0);

    repeat (2) tick();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
